// File: rtl/tank_pkg.sv
// Shared map geometry and arbiter state encoding for the tank game map port.
package tank_pkg;
  localparam int MAP_W      = 64;
  localparam int MAP_H      = 44;
  localparam int COORD_W    = 6;
  localparam int MAP_ADDR_W = 12;

  typedef enum logic [1:0] {RENDER, SERVE, DRAIN} arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] ptr_o
);
  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (en_i && !found && req_i[PW'(idx)]) begin
        found            = 1'b1;
        gnt_o[PW'(idx)]  = 1'b1;
        ptr_d            = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/map_port_arbiter.sv
// Shares the single wall-map RAM port between the VGA renderer and the game
// requesters; requesters only get the port in a window opened at frame end.
module map_port_arbiter #(
  parameter int N_REQ         = 2,
  parameter int MAP_W         = tank_pkg::MAP_W,
  parameter int MAP_H         = tank_pkg::MAP_H,
  parameter int WINDOW_CYCLES = 32000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_vga_buzy,
  input  logic [tank_pkg::COORD_W-1:0]        i_vga_x,
  input  logic [tank_pkg::COORD_W-1:0]        i_vga_y,
  output logic                                o_vga_is_wall,
  input  logic [N_REQ-1:0]                    i_req,
  input  logic [N_REQ-1:0]                    i_we,
  input  logic [N_REQ*tank_pkg::COORD_W-1:0]  i_x,
  input  logic [N_REQ*tank_pkg::COORD_W-1:0]  i_y,
  input  logic [N_REQ-1:0]                    i_wdata,
  output logic [N_REQ-1:0]                    o_gnt,
  output logic [N_REQ-1:0]                    o_rvalid,
  output logic                                o_rdata,
  output logic                                o_window,
  output logic [tank_pkg::MAP_ADDR_W-1:0]     o_mem_addr,
  output logic                                o_mem_we,
  output logic                                o_mem_wdata,
  input  logic                                i_mem_rdata
);
  import tank_pkg::*;

  localparam int CW    = COORD_W;
  localparam int AW    = MAP_ADDR_W;
  localparam int CNT_W = $clog2(WINDOW_CYCLES);
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  function automatic logic [AW-1:0] cell_addr(input logic [CW-1:0] y, input logic [CW-1:0] x);
    return AW'(y) * AW'(MAP_W) + AW'(x);
  endfunction

  arb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_REQ-1:0] rvalid_q;
  logic             oob_q;
  logic             serve;
  logic [IW-1:0]    ptr, win;
  logic [CW-1:0]    win_x, win_y;
  logic             win_oob;

  assign serve = (state_q == SERVE);

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req_i (i_req),
    .en_i  (serve),
    .gnt_o (o_gnt),
    .ptr_o (ptr)
  );

  // Without a grant the mux index is don't-care; the pointer is a cheap default.
  always_comb begin
    win = ptr;
    for (int i = 0; i < N_REQ; i++)
      if (o_gnt[i]) win = IW'(i);
  end

  assign win_x   = i_x[int'(win)*CW +: CW];
  assign win_y   = i_y[int'(win)*CW +: CW];
  assign win_oob = (win_y >= CW'(MAP_H));

  always_comb begin
    o_mem_addr  = cell_addr(i_vga_y, i_vga_x);
    o_mem_we    = 1'b0;
    o_mem_wdata = 1'b0;
    if (serve) begin
      o_mem_addr = cell_addr(win_y, win_x);
      if (|o_gnt && i_we[win] && !win_oob) begin
        o_mem_we    = 1'b1;
        o_mem_wdata = i_wdata[win];
      end
    end
  end

  // Window FSM; the counter runs through DRAIN so DRAIN sits at WINDOW_CYCLES-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RENDER;
      cnt_q    <= '0;
      rvalid_q <= '0;
      oob_q    <= 1'b0;
    end else begin
      rvalid_q <= o_gnt & ~i_we;
      oob_q    <= win_oob;
      case (state_q)
        RENDER: if (!i_vga_buzy) begin
          state_q <= SERVE;
          cnt_q   <= '0;
        end
        SERVE: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WINDOW_CYCLES - 2)) state_q <= DRAIN;
        end
        DRAIN: begin
          cnt_q   <= cnt_q + 1'b1;
          state_q <= RENDER;
        end
        default: state_q <= RENDER;
      endcase
    end
  end

  assign o_window      = (state_q != RENDER);
  assign o_rvalid      = rvalid_q;
  assign o_rdata       = |rvalid_q & (oob_q | i_mem_rdata);
  assign o_vga_is_wall = (state_q == RENDER) & i_mem_rdata;
endmodule

// File: tb/tb_map_port_arbiter.sv
// Directed + randomized bench for map_port_arbiter against a cycle-level
// reference model (window countdown, shadow wall map, round-robin pointer).
module tb_map_port_arbiter;
  localparam int N_REQ = 2;
  localparam int MAP_H = 44;
  localparam int WIN   = 32000;

  logic        clk;
  logic        rst, buzy;
  logic [5:0]  vx, vy;
  logic        o_vga_is_wall;
  logic [1:0]  req, we, wd;
  logic [11:0] ix, iy;
  logic [1:0]  o_gnt, o_rvalid;
  logic        o_rdata, o_window;
  logic [11:0] mem_addr;
  logic        mem_we, mem_wdata;
  bit          mem_rdata;

  bit          ram [0:4095];
  logic        ld_en;
  logic [11:0] ld_a;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit   map_m [0:63][0:63];
  int   win_left = 0;
  int   m_ptr = 0;
  logic [1:0] pend_rv = '0;
  logic pend_rd = 1'b0;
  bit   prev_render = 0;
  logic [5:0] pvx = '0, pvy = '0;
  int   win_cnt = 0;

  logic [1:0]  obs_gnt, obs_rv;
  logic        obs_rd, obs_win, obs_we, obs_wall;
  logic [11:0] obs_addr;

  map_port_arbiter dut (
    .clk(clk), .rst(rst), .i_vga_buzy(buzy), .i_vga_x(vx), .i_vga_y(vy),
    .o_vga_is_wall(o_vga_is_wall), .i_req(req), .i_we(we), .i_x(ix), .i_y(iy),
    .i_wdata(wd), .o_gnt(o_gnt), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
    .o_window(o_window), .o_mem_addr(mem_addr), .o_mem_we(mem_we),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external synchronous RAM
  always @(posedge clk) begin
    if (ld_en)       ram[ld_a] <= 1'b1;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rq(input int r, input logic w, input int x, input int y, input logic d);
    we[r] = w;
    wd[r] = d;
    ix[r*6 +: 6] = 6'(x);
    iy[r*6 +: 6] = 6'(y);
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic step();
    int w, x, y;
    bit oob;
    logic [1:0] eg;
    @(negedge clk);
    obs_gnt = o_gnt; obs_rv = o_rvalid; obs_rd = o_rdata; obs_win = o_window;
    obs_addr = mem_addr; obs_we = mem_we; obs_wall = o_vga_is_wall;
    if (o_window) win_cnt++;
    w = -1; x = 0; y = 0; oob = 0; eg = '0;
    if (win_left > 1)
      for (int k = 0; k < N_REQ; k++)
        if (w < 0 && req[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
    if (w >= 0) begin
      eg[w] = 1'b1;
      x = int'(ix[w*6 +: 6]);
      y = int'(iy[w*6 +: 6]);
      oob = (y >= MAP_H);
    end
    chk("window", 32'(obs_win), 32'(win_left > 0));
    chk("gnt", 32'(obs_gnt), 32'(eg));
    chk("rvalid", 32'(obs_rv), 32'(pend_rv));
    if (pend_rv != 0) chk("rdata", 32'(obs_rd), 32'(pend_rd));
    if (w >= 0) begin
      chk("gnt_addr", 32'(obs_addr), 32'(y * 64 + x));
      chk("gnt_we", 32'(obs_we), 32'(we[w] && !oob));
      if (we[w] && !oob) chk("gnt_wdata", 32'(mem_wdata), 32'(wd[w]));
    end else chk("idle_we", 32'(obs_we), 32'd0);
    if (win_left == 0) begin
      chk("vga_addr", 32'(obs_addr), 32'(int'(vy) * 64 + int'(vx)));
      if (prev_render) chk("vga_wall", 32'(obs_wall), 32'(map_m[pvy][pvx]));
    end else chk("vga_wall_blank", 32'(obs_wall), 32'd0);

    @(posedge clk);
    if (rst) begin
      win_left = 0; m_ptr = 0; pend_rv = '0; prev_render = 0;
    end else begin
      pend_rv = '0;
      if (w >= 0) begin
        m_ptr = (w + 1) % N_REQ;
        if (!we[w]) begin
          pend_rv[w] = 1'b1;
          pend_rd = oob ? 1'b1 : map_m[y][x];
        end else if (!oob) map_m[y][x] = wd[w];
      end
      prev_render = (win_left == 0);
      pvx = vx; pvy = vy;
      if (win_left > 0) win_left--;
      else if (!buzy) win_left = WIN;
    end
    #1;
  endtask

  initial begin
    logic [5:0] tx, ty;
    rst = 1; buzy = 1; vx = 0; vy = 0; req = 0; we = 0; wd = 0; ix = 0; iy = 0;
    ld_en = 0; ld_a = 0;
    for (int a = 0; a < 64; a++) for (int b = 0; b < 64; b++) map_m[a][b] = 0;

    // preload walls while in reset
    ld_en = 1; ld_a = {6'd3, 6'd5}; map_m[3][5] = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 30; i++) begin
      ty = 6'($urandom_range(0, 42));
      tx = 6'($urandom_range(0, 63));
      if (ty == 6'd20) ty = 6'd2;
      ld_a = {ty, tx}; map_m[ty][tx] = 1;
      @(posedge clk); #1;
    end
    ld_en = 0;
    @(posedge clk); #1;
    rst = 0;

    step();
    chk("rst_window", 32'(obs_win), 0);
    chk("rst_gnt", 32'(obs_gnt), 0);
    chk("rst_rvalid", 32'(obs_rv), 0);
    chk("rst_addr", 32'(obs_addr), 0);
    chk("rst_we", 32'(obs_we), 0);

    // RENDER passthrough, requests must wait
    vx = 6'd5; vy = 6'd3; req = 2'b11;
    step();
    chk("render_addr", 32'(obs_addr), 32'h0C5);
    chk("render_gnt", 32'(obs_gnt), 0);
    step();
    chk("render_wall", 32'(obs_wall), 1);
    for (int i = 0; i < 20; i++) begin
      vx = 6'($urandom); vy = 6'($urandom);
      step();
    end

    // window 1: alternation
    win_cnt = 0;
    buzy = 0; step(); buzy = 1;
    set_rq(0, 0, 1, 1, 0); set_rq(1, 0, 2, 2, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("alt_gnt", 32'(obs_gnt), (i % 2 == 0) ? 32'd1 : 32'd2);
    end

    // write then read back through the other requester
    req = 2'b01; set_rq(0, 1, 10, 20, 1);
    step();
    chk("wr_we", 32'(obs_we), 1);
    chk("wr_addr", 32'(obs_addr), 32'(20 * 64 + 10));
    req = 2'b10; set_rq(1, 0, 10, 20, 0);
    step();
    chk("rd_gnt", 32'(obs_gnt), 2);
    req = 2'b00;
    step();
    chk("rd_rvalid", 32'(obs_rv), 2);
    chk("rd_rdata", 32'(obs_rd), 1);

    // boundary rows
    req = 2'b01; set_rq(0, 0, 7, 44, 0);
    step();
    chk("oob_rd_gnt", 32'(obs_gnt), 1);
    chk("oob_rd_we", 32'(obs_we), 0);
    req = 2'b00;
    step();
    chk("oob_rvalid", 32'(obs_rv), 1);
    chk("oob_rdata", 32'(obs_rd), 1);
    req = 2'b01; set_rq(0, 1, 7, 63, 1);
    step();
    chk("oob_wr_gnt", 32'(obs_gnt), 1);
    chk("oob_wr_we", 32'(obs_we), 0);
    req = 2'b00;
    step();
    chk("oob_ram_untouched", 32'(ram[63 * 64 + 7]), 0);
    req = 2'b01; set_rq(0, 0, 7, 43, 0);
    step();
    req = 2'b00;
    step();
    chk("row43_rdata", 32'(obs_rd), 0);

    // random traffic inside the window; stray buzy lows must be ignored
    for (int i = 0; i < 400; i++) begin
      req = 2'($urandom);
      for (int r = 0; r < N_REQ; r++)
        set_rq(r, 1'($urandom), $urandom_range(0, 63), $urandom_range(0, 63), 1'($urandom));
      vx = 6'($urandom); vy = 6'($urandom);
      buzy = ($urandom_range(0, 15) != 0);
      step();
    end
    buzy = 1; req = 0; vx = 6'd1; vy = 6'd2;

    // window end
    for (int g = 0; g < 40000 && win_left != 2; g++) step();
    chk("reach_last_serve", win_left, 2);
    req = 2'b01; set_rq(0, 0, 9, 20, 0);
    step();
    chk("last_gnt", 32'(obs_gnt), 1);
    step();
    chk("drain_gnt", 32'(obs_gnt), 0);
    chk("drain_rvalid", 32'(obs_rv), 1);
    chk("drain_window", 32'(obs_win), 1);
    step();
    chk("resume_window", 32'(obs_win), 0);
    chk("resume_addr", 32'(obs_addr), 32'(2 * 64 + 1));
    chk("resume_gnt", 32'(obs_gnt), 0);
    req = 0;
    chk("win1_len", win_cnt, WIN);
    repeat (3) step();

    // reset at counter 100
    buzy = 0; step(); buzy = 1;
    req = 2'b11; set_rq(0, 0, 3, 3, 0); set_rq(1, 0, 4, 4, 0);
    for (int g = 0; g < 200 && win_left != WIN - 100; g++) step();
    chk("reach_cnt100", win_left, WIN - 100);
    rst = 1; step(); rst = 0;
    step();
    chk("rst_mid_window", 32'(obs_win), 0);
    chk("rst_mid_gnt", 32'(obs_gnt), 0);
    chk("rst_mid_rvalid", 32'(obs_rv), 0);

    // fresh window: pointer restarted, full length counted from 0
    win_cnt = 0;
    buzy = 0; step(); buzy = 1;
    step();
    chk("rst_ptr_gnt", 32'(obs_gnt), 1);
    req = 0;
    for (int g = 0; g < 40000 && win_left > 0; g++) step();
    chk("win2_len", win_cnt, WIN);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
